// File: rtl/chip8_loader_if.sv
// rtl/chip8_loader_if.sv - UART byte input and program-memory/status bundle for the CHIP-8 loader.
interface chip8_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic [7:0]            rx_i;
    logic                  rx_i_v;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_d;
    logic                  cpu_hold;
    logic                  busy;
    logic                  load_done;
    logic                  load_err;
    logic [1:0]            err_code;

    modport master (
        output rx_i, rx_i_v,
        input  mem_we, mem_waddr, mem_d, cpu_hold, busy, load_done, load_err, err_code
    );

    modport slave (
        input  rx_i, rx_i_v,
        output mem_we, mem_waddr, mem_d, cpu_hold, busy, load_done, load_err, err_code
    );
endinterface

// File: rtl/chip8_loader.sv
// rtl/chip8_loader.sv - framed UART program upload into CHIP-8 memory with checksum and gap timeout.
module chip8_loader #(
    parameter int         ADDR_WIDTH = 12,
    parameter int         DATA_WIDTH = 8,
    parameter int         LOAD_BASE  = 512,
    parameter int         MAX_LEN    = 3584,
    parameter logic [7:0] SYNC_BYTE  = 8'hC8,
    parameter int         TIMEOUT    = 2000000
) (
    input  logic           clk,
    input  logic           rst,
    chip8_loader_if.slave  bus
);
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM
    } state_t;

    state_t                state_q, state_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [3:0]            len_h_q, len_h_d;
    logic [11:0]           cnt_q, cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_d_q, mem_d_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [11:0]           len_w;
    logic                  timeout;

    assign len_w   = {len_h_q, bus.rx_i};
    // Any strobe restarts the gap, so a byte and a timeout can never coincide.
    assign timeout = (state_q != ST_IDLE) && !bus.rx_i_v && (gap_q == GAP_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        len_h_d     = len_h_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_d_d     = mem_d_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        err_code_d  = err_code_q;
        gap_d       = (state_q == ST_IDLE || bus.rx_i_v) ? '0 : gap_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_i_v && bus.rx_i == SYNC_BYTE) begin
                    state_d    = ST_LEN_H;
                    cpu_hold_d = 1'b1;
                    load_err_d = 1'b0;
                    err_code_d = 2'd0;
                end
            end
            ST_LEN_H: begin
                if (bus.rx_i_v) begin
                    len_h_d = bus.rx_i[3:0];
                    state_d = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (bus.rx_i_v) begin
                    if (len_w == 12'd0 || 32'(len_w) > MAX_LEN) begin
                        state_d    = ST_IDLE;
                        load_err_d = 1'b1;
                        err_code_d = 2'd1;
                    end else begin
                        state_d = ST_DATA;
                        addr_d  = ADDR_WIDTH'(LOAD_BASE);
                        csum_d  = 8'd0;
                        cnt_d   = len_w;
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_i_v) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = addr_q;
                    mem_d_d     = DATA_WIDTH'(bus.rx_i);
                    addr_d      = addr_q + 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    csum_d      = csum_q + bus.rx_i;
                    if (cnt_q == 12'd1) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (bus.rx_i_v) begin
                    state_d = ST_IDLE;
                    if (bus.rx_i == csum_q) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                        err_code_d = 2'd2;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            state_d    = ST_IDLE;
            load_err_d = 1'b1;
            err_code_d = 2'd3;
            gap_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            len_h_q     <= 4'd0;
            cnt_q       <= 12'd0;
            csum_q      <= 8'd0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_d_q     <= '0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            len_h_q     <= len_h_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_d_q     <= mem_d_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_d     = mem_d_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.load_done = load_done_q;
    assign bus.load_err  = load_err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_chip8_loader.sv
// tb/tb_chip8_loader.sv - directed vector table plus timeout and mid-frame reset sequences for chip8_loader.
module tb_chip8_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    logic [7:0] mem_model [0:4095];

    always #5 clk = ~clk;

    chip8_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();

    chip8_loader #(
        .ADDR_WIDTH(12), .DATA_WIDTH(8), .LOAD_BASE(512), .MAX_LEN(3584),
        .SYNC_BYTE(8'hC8), .TIMEOUT(100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.mem_we) begin
            wr_cnt <= wr_cnt + 1;
            mem_model[bus.mem_waddr] <= bus.mem_d;
        end
    end

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        we;
        logic [11:0] a;
        logic [7:0]  d;
        logic        hold;
        logic        busy;
        logic        done;
        logic        err;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [7:0] b, logic we, logic [11:0] a, logic [7:0] d,
                                logic hold, logic busy, logic done, logic err, logic [1:0] code);
        vec_t r;
        r.v = v; r.b = b; r.we = we; r.a = a; r.d = d;
        r.hold = hold; r.busy = busy; r.done = done; r.err = err; r.code = code;
        return r;
    endfunction

    task automatic send(input logic v, input logic [7:0] b);
        @(negedge clk);
        bus.rx_i   = b;
        bus.rx_i_v = v;
        @(posedge clk);
        #1;
        bus.rx_i_v = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_out();
        return {7'd0, bus.mem_we, bus.mem_we ? bus.mem_waddr : 12'd0, bus.mem_we ? bus.mem_d : 8'd0,
                bus.cpu_hold, bus.busy, bus.load_done, bus.load_err, bus.err_code};
    endfunction

    function automatic logic [31:0] pack_exp(vec_t r);
        return {7'd0, r.we, r.we ? r.a : 12'd0, r.we ? r.d : 8'd0,
                r.hold, r.busy, r.done, r.err, r.code};
    endfunction

    initial begin
        bus.rx_i   = 8'h00;
        bus.rx_i_v = 1'b0;

        // Good 3-byte frame
        vecs.push_back(mk(1, 8'hC8, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h03, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h12, 1, 12'h200, 8'h12, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h34, 1, 12'h201, 8'h34, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h56, 1, 12'h202, 8'h56, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h9C, 0, 12'h000, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0));
        // Bad checksum
        vecs.push_back(mk(1, 8'hC8, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h02, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'hAA, 1, 12'h200, 8'hAA, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'hBB, 1, 12'h201, 8'hBB, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0, 1, 2));
        // Recovery 1-byte frame
        vecs.push_back(mk(1, 8'hC8, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h01, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h05, 1, 12'h200, 8'h05, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h05, 0, 12'h000, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0));
        // LEN = 3585 and LEN = 0
        vecs.push_back(mk(1, 8'hC8, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0E, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h01, 0, 12'h000, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 8'hC8, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0, 1, 1));
        // Non-sync bytes while idle
        vecs.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 8'hFF, 0, 12'h000, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 8'h7E, 0, 12'h000, 8'h00, 1, 0, 0, 1, 1));
        // Sync byte inside payload, strobed every cycle
        vecs.push_back(mk(1, 8'hC8, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h03, 0, 12'h000, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'hC8, 1, 12'h200, 8'hC8, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h01, 1, 12'h201, 8'h01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'hC8, 1, 12'h202, 8'hC8, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h91, 0, 12'h000, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.mem_we, bus.mem_waddr, bus.mem_d, bus.cpu_hold, bus.busy,
                                bus.load_done, bus.load_err, bus.err_code}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].v, vecs[i].b);
            check($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
        end

        // Gap timeout after two of four payload bytes
        wr_cnt = 0;
        send(1, 8'hC8);
        send(1, 8'h00);
        send(1, 8'h04);
        send(1, 8'h01);
        send(1, 8'h02);
        repeat (99) @(posedge clk);
        #1;
        check("timeout_not_yet", {bus.busy, bus.load_err, 6'd0, bus.err_code}, {1'b1, 1'b0, 6'd0, 2'd0});
        @(posedge clk);
        #1;
        check("timeout_fired", {bus.busy, bus.cpu_hold, bus.load_err, 5'd0, bus.err_code},
              {1'b0, 1'b1, 1'b1, 5'd0, 2'd3});
        check("timeout_writes", wr_cnt, 2);

        // Reset in the middle of a frame
        send(1, 8'hC8);
        send(1, 8'h00);
        send(1, 8'h05);
        send(1, 8'h11);
        send(1, 8'h22);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midframe_reset", {bus.mem_we, bus.mem_waddr, bus.mem_d, bus.cpu_hold, bus.busy,
                                 bus.load_done, bus.load_err, bus.err_code}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(1, 8'hC8);
        send(1, 8'h00);
        send(1, 8'h02);
        send(1, 8'h33);
        send(1, 8'h44);
        send(1, 8'h77);
        check("reload_done", {bus.load_done, bus.cpu_hold, bus.load_err, bus.busy}, 4'b1000);
        @(posedge clk);
        #1;
        check("reload_mem_200", mem_model[12'h200], 8'h33);
        check("reload_mem_201", mem_model[12'h201], 8'h44);
        check("frame_with_sync_mem_202", mem_model[12'h202], 8'hC8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
